// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port owner: round-robin arbitration between two pixel
// requesters plus a frame-clear engine issuing one write per clock.
module fb_write_arbiter #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [9:0]        req0_x,
  input  logic [8:0]        req0_y,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [9:0]        req1_x,
  input  logic [8:0]        req1_y,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              we
);

  localparam int unsigned     NPIX    = H_RES * V_RES;
  localparam logic [ADDR_W:0] CLR_END = (ADDR_W+1)'(NPIX);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_gnt;
  logic [ADDR_W:0]   r_clr_cnt;
  logic [DATA_W-1:0] r_clr_color;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_we;
  logic              r_done;

  logic              w_idle;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer0;
  logic              w_xfer1;
  logic              w_xfer;
  logic              w_clr_go;
  logic              w_clr_end;
  logic [9:0]        w_sel_x;
  logic [8:0]        w_sel_y;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_onscreen;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [8:0] y);
    return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
  endfunction

  // r_last_gnt = 1 means requester 1 won last, so requester 0 wins the next tie
  assign w_idle     = (r_state == S_IDLE);
  assign w_gnt0     = req0_valid & (~req1_valid | r_last_gnt);
  assign w_gnt1     = req1_valid & (~req0_valid | ~r_last_gnt);
  assign req0_ready = w_idle & ~clear_start & w_gnt0;
  assign req1_ready = w_idle & ~clear_start & w_gnt1;
  assign w_xfer0    = req0_valid & req0_ready;
  assign w_xfer1    = req1_valid & req1_ready;
  assign w_xfer     = w_xfer0 | w_xfer1;
  assign w_clr_go   = w_idle & clear_start;

  assign w_sel_x    = w_xfer1 ? req1_x    : req0_x;
  assign w_sel_y    = w_xfer1 ? req1_y    : req0_y;
  assign w_sel_data = w_xfer1 ? req1_data : req0_data;
  assign w_onscreen = (32'(w_sel_x) < H_RES) && (32'(w_sel_y) < V_RES);

  always_comb begin
    w_state_nxt = r_state;
    w_clr_end   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clear_start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        // counter reaching NPIX means every address has been written
        if (r_clr_cnt == CLR_END) begin
          w_state_nxt = S_IDLE;
          w_clr_end   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last_gnt  <= 1'b1;
      r_clr_cnt   <= '0;
      r_clr_color <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= 1'b0;
      r_done  <= w_clr_end;
      if (w_clr_go) begin
        r_clr_cnt   <= '0;
        r_clr_color <= clear_color;
      end else if (w_xfer) begin
        r_last_gnt <= w_xfer1;
        if (w_onscreen) begin
          r_addr <= pix_addr(w_sel_x, w_sel_y);
          r_data <= w_sel_data;
          r_we   <= 1'b1;
        end
      end
      if ((r_state == S_CLEAR) && !w_clr_end) begin
        r_addr    <= r_clr_cnt[ADDR_W-1:0];
        r_data    <= r_clr_color;
        r_we      <= 1'b1;
        r_clr_cnt <= r_clr_cnt + (ADDR_W+1)'(1);
      end
    end
  end

  assign w_addr     = r_addr;
  assign w_data     = r_data;
  assign we         = r_we;
  assign clear_done = r_done;
  assign clear_busy = (r_state == S_CLEAR);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter on a small 8x4 frame: cycle model plus directed
// scenarios with literal expectations.
module tb_fb_write_arbiter;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int NP = H * V;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 1'b0;
  logic [9:0]    req0_x = '0;
  logic [8:0]    req0_y = '0;
  logic [DW-1:0] req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [9:0]    req1_x = '0;
  logic [8:0]    req1_y = '0;
  logic [DW-1:0] req1_data = '0;
  logic          req1_ready;
  logic          clear_start = 1'b0;
  logic [DW-1:0] clear_color = '0;
  logic          clear_busy;
  logic          clear_done;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          we;

  fb_write_arbiter #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .w_addr(w_addr), .w_data(w_data), .we(we)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int d; } pix_t;
  typedef struct { int a; int d; int c; } wr_t;

  pix_t q0[$];
  pix_t q1[$];
  wr_t  wlog[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   acc_cnt[2] = '{0, 0};
  int   last_acc_cyc = 0;
  int   n_done = 0;
  int   done_cyc = 0;

  // Model state: what the write port must show, from the behavioural rules
  bit m_clearing = 0;
  int m_idx = 0;
  int m_color = 0;
  int m_last = 1;
  bit e_we = 0;
  bit e_busy = 0;
  bit e_done = 0;
  int e_addr = 0;
  int e_data = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit grant(input int n);
    if (n == 0) return req0_valid && (!req1_valid || m_last == 1);
    return req1_valid && (!req0_valid || m_last == 0);
  endfunction

  function automatic bit exp_ready(input int n);
    return !m_clearing && !clear_start && grant(n);
  endfunction

  task automatic accept(input int n, input int x, input int y, input int d);
    m_last = n;
    if (x < H && y < V) begin
      e_we   = 1;
      e_addr = y * H + x;
      e_data = d;
    end
  endtask

  task automatic model_step();
    bit a0;
    bit a1;
    a0 = req0_valid && exp_ready(0);
    a1 = req1_valid && exp_ready(1);
    e_we   = 0;
    e_done = 0;
    if (!m_clearing) begin
      if (clear_start) begin
        m_clearing = 1;
        m_idx      = 0;
        m_color    = int'(clear_color);
      end else if (a0) accept(0, int'(req0_x), int'(req0_y), int'(req0_data));
      else if (a1) accept(1, int'(req1_x), int'(req1_y), int'(req1_data));
    end else if (m_idx == NP) begin
      m_clearing = 0;
      e_done     = 1;
    end else begin
      e_we   = 1;
      e_addr = m_idx;
      e_data = m_color;
      m_idx++;
    end
    e_busy = m_clearing;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_clearing = 0; m_idx = 0; m_color = 0; m_last = 1;
      e_we = 0; e_busy = 0; e_done = 0; e_addr = 0; e_data = 0;
    end else begin
      model_step();
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    chk("req0_ready", 32'(req0_ready), 32'(exp_ready(0)));
    chk("req1_ready", 32'(req1_ready), 32'(exp_ready(1)));
    chk("we", 32'(we), 32'(e_we));
    chk("clear_busy", 32'(clear_busy), 32'(e_busy));
    chk("clear_done", 32'(clear_done), 32'(e_done));
    if (e_we) begin
      chk("w_addr", 32'(w_addr), e_addr);
      chk("w_data", 32'(w_data), e_data);
    end
    if (we) wlog.push_back('{int'(w_addr), int'(w_data), cyc});
  end

  task automatic apply_q();
    req0_valid = (q0.size() > 0);
    if (q0.size() > 0) begin
      req0_x = 10'(q0[0].x); req0_y = 9'(q0[0].y); req0_data = 16'(q0[0].d);
    end
    req1_valid = (q1.size() > 0);
    if (q1.size() > 0) begin
      req1_x = 10'(q1[0].x); req1_y = 9'(q1[0].y); req1_data = 16'(q1[0].d);
    end
  endtask

  task automatic cycle();
    bit a0;
    bit a1;
    @(negedge clk);
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    if (a0 || a1) last_acc_cyc = cyc;
    if (clear_done) begin
      n_done++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (a0) begin q0.delete(0); acc_cnt[0]++; end
    if (a1) begin q1.delete(0); acc_cnt[1]++; end
    clear_start = 1'b0;
    apply_q();
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete(); apply_q();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int rr_a[8] = '{0, 8, 1, 9, 2, 10, 3, 11};
    int rr_d[8] = '{'hA000, 'hB000, 'hA001, 'hB001, 'hA002, 'hB002, 'hA003, 'hB003};
    bit found;

    apply_q();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset then idle
    repeat (10) cycle();
    chk("idle_w_addr", 32'(w_addr), 0);
    chk("idle_writes", wlog.size(), 0);

    // single request: (5,2) on an 8-wide frame -> address 21
    wlog.delete();
    acc = acc_cnt[0];
    q0.push_back('{5, 2, 'h0F0F});
    apply_q();
    cycle();
    chk("single_accept", acc_cnt[0] - acc, 1);
    cycle();
    chk("single_nwrites", wlog.size(), 1);
    chk("single_addr", wlog[0].a, 21);
    chk("single_data", wlog[0].d, 'h0F0F);
    chk("single_latency", wlog[0].c, last_acc_cyc + 1);

    // last on-screen pixel -> top address
    q1.push_back('{7, 3, 'h7777});
    apply_q();
    repeat (2) cycle();
    chk("corner_nwrites", wlog.size(), 2);
    chk("corner_addr", wlog[1].a, 31);
    chk("corner_data", wlog[1].d, 'h7777);

    // round robin after reset: requester 0 wins the first tie
    do_reset();
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{i, 0, 'hA000 + i});
      q1.push_back('{i, 1, 'hB000 + i});
    end
    apply_q();
    for (int i = 0; i < 20 && (q0.size() > 0 || q1.size() > 0); i++) cycle();
    chk("rr_drained", q0.size() + q1.size(), 0);
    repeat (2) cycle();
    chk("rr_nwrites", wlog.size(), 8);
    if (wlog.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("rr_addr%0d", i), wlog[i].a, rr_a[i]);
        chk($sformatf("rr_data%0d", i), wlog[i].d, rr_d[i]);
        chk($sformatf("rr_cyc%0d", i), wlog[i].c, wlog[0].c + i);
      end
    end

    // off-screen pixels: accepted, never written
    wlog.delete();
    acc = acc_cnt[1];
    q1.push_back('{640, 0, 'hC000});
    q1.push_back('{0, 480, 'hC001});
    q1.push_back('{8, 0, 'hC002});
    q1.push_back('{0, 4, 'hC003});
    apply_q();
    repeat (6) cycle();
    chk("offscreen_accepts", acc_cnt[1] - acc, 4);
    chk("offscreen_writes", wlog.size(), 0);

    // clear racing a requester, with an ignored second clear_start mid-way
    wlog.delete();
    n_done = 0;
    acc = acc_cnt[0];
    q0.push_back('{1, 1, 'h1111});
    apply_q();
    clear_color = 16'h0ABC;
    clear_start = 1'b1;
    #1;
    chk("clr_req0_blocked", 32'(req0_ready), 0);
    for (int i = 0; i < 100 && n_done == 0; i++) begin
      if (i == 12) begin
        clear_color = 16'h5555;
        clear_start = 1'b1;
      end
      cycle();
    end
    chk("clr_done_count", n_done, 1);
    chk("clr_req0_after_done", acc_cnt[0] - acc, 1);
    repeat (2) cycle();
    chk("clr_nwrites", wlog.size(), NP + 1);
    if (wlog.size() == NP + 1) begin
      for (int i = 0; i < NP; i++) begin
        chk($sformatf("clr_addr%0d", i), wlog[i].a, i);
        chk($sformatf("clr_data%0d", i), wlog[i].d, 'h0ABC);
        chk($sformatf("clr_cyc%0d", i), wlog[i].c, wlog[0].c + i);
      end
      chk("clr_done_align", done_cyc, wlog[NP-1].c + 1);
      chk("clr_req_addr", wlog[NP].a, 9);
      chk("clr_req_data", wlog[NP].d, 'h1111);
    end
    chk("clr_busy_after", 32'(clear_busy), 0);
    chk("clr_done_after", n_done, 1);

    // reset in the middle of a clear
    wlog.delete();
    n_done = 0;
    clear_color = 16'h1234;
    clear_start = 1'b1;
    cycle();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (we && w_addr == AW'(10)) found = 1;
    end
    chk("rmc_reached_write10", 32'(found), 1);
    #2 rst = 1'b1;
    #1;
    chk("rmc_we_async", 32'(we), 0);
    chk("rmc_busy_async", 32'(clear_busy), 0);
    chk("rmc_addr_async", 32'(w_addr), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    apply_q();
    repeat (40) cycle();
    chk("rmc_no_done", n_done, 0);
    chk("rmc_busy_idle", 32'(clear_busy), 0);
    chk("rmc_writes_before_reset", wlog.size(), 11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
